// File: rtl/multi_tick_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multi_tick_pkg
//  Purpose  : Shared constants and types for the multi-channel timebase.
//             US_PER_MS sets the us->ms prescale ratio. tick_mode_e selects
//             periodic or one-shot channel behaviour. ch_cfg_t bundles one
//             channel's runtime configuration at the default period width.
//  Revision : 1.0 - initial release
// ============================================================================
package multi_tick_pkg;

  localparam int US_PER_MS = 1000;
  localparam int CFG_DIVW  = 16;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } tick_mode_e;

  typedef struct packed {
    tick_mode_e          mode;
    logic [CFG_DIVW-1:0] period;
  } ch_cfg_t;

  // Number of clk cycles in one millisecond for a given clock frequency.
  function automatic int unsigned ms_cycles(input int unsigned clkmhz);
    return clkmhz * US_PER_MS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : tick_prescaler
//  Purpose  : Shared 1 us / 1 ms tick generator, one instance for all channels.
//  Ports    : clk     - clock
//             rst     - synchronous active-high reset
//             us_tick - 1-cycle pulse every CLKMHZ cycles
//             ms_tick - 1-cycle pulse every US_PER_MS us_ticks, one cycle
//                       after the us_tick that completes the millisecond
//  Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler
  import multi_tick_pkg::*;
#(
  parameter int CLKMHZ = 100
) (
  input  logic clk,
  input  logic rst,
  output logic us_tick,
  output logic ms_tick
);

  localparam int USW = (CLKMHZ > 1) ? $clog2(CLKMHZ) : 1;
  localparam int MSW = $clog2(US_PER_MS);

  logic [USW-1:0] us_cnt_q, us_cnt_d;
  logic [MSW-1:0] ms_cnt_q, ms_cnt_d;
  logic           us_tick_q, us_tick_d;
  logic           ms_tick_q, ms_tick_d;

  always_comb begin
    us_cnt_d  = us_cnt_q;
    us_tick_d = 1'b0;
    if (us_cnt_q == USW'(CLKMHZ - 1)) begin
      us_cnt_d  = '0;
      us_tick_d = 1'b1;
    end else begin
      us_cnt_d = us_cnt_q + USW'(1);
    end
  end

  // The ms counter advances on the registered us pulse, so ms_tick trails
  // the us_tick that closes each millisecond by exactly one cycle.
  always_comb begin
    ms_cnt_d  = ms_cnt_q;
    ms_tick_d = 1'b0;
    if (us_tick_q) begin
      if (ms_cnt_q == MSW'(US_PER_MS - 1)) begin
        ms_cnt_d  = '0;
        ms_tick_d = 1'b1;
      end else begin
        ms_cnt_d = ms_cnt_q + MSW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      us_cnt_q  <= '0;
      ms_cnt_q  <= '0;
      us_tick_q <= 1'b0;
      ms_tick_q <= 1'b0;
    end else begin
      us_cnt_q  <= us_cnt_d;
      ms_cnt_q  <= ms_cnt_d;
      us_tick_q <= us_tick_d;
      ms_tick_q <= ms_tick_d;
    end
  end

  assign us_tick = us_tick_q;
  assign ms_tick = ms_tick_q;

endmodule
`default_nettype wire

// File: rtl/multi_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : multi_tick_gen
//  Purpose  : Multi-channel timebase. A shared prescaler produces 1 us and
//             1 ms ticks; NCH channels each emit a 1-cycle strobe every
//             'period' ms (periodic) or once (one-shot), configurable at
//             runtime through a write port.
//  Ports    : clk, rst                - clock, synchronous active-high reset
//             ch_en[NCH]              - per-channel enable (level)
//             cfg_we/cfg_ch/cfg_period/cfg_oneshot - channel config write
//             us_tick, ms_tick        - shared timebase pulses
//             strobe[NCH]             - per-channel 1-cycle strobe
//             busy[NCH]               - channel enabled, armed, period != 0
//             led[NCH]                - toggles on each strobe (only when
//                                       MULTI_TICK_LED_EN is defined)
//  Config   : MULTI_TICK_LED_EN - adds the led port and its toggle flops
//  Revision : 1.0 - initial release
// ============================================================================
module multi_tick_gen
  import multi_tick_pkg::*;
#(
  parameter int CLKMHZ     = 100,
  parameter int NCH        = 4,
  parameter int DIVW       = 16,
  parameter int PERIOD_DEF = 1000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NCH-1:0]                       ch_en,
  input  logic                                 cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [DIVW-1:0]                      cfg_period,
  input  logic                                 cfg_oneshot,
  output logic                                 us_tick,
  output logic                                 ms_tick,
  output logic [NCH-1:0]                       strobe,
  output logic [NCH-1:0]                       busy
`ifdef MULTI_TICK_LED_EN
  ,
  output logic [NCH-1:0]                       led
`endif
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  tick_prescaler #(
    .CLKMHZ (CLKMHZ)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .us_tick (us_tick),
    .ms_tick (ms_tick)
  );

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [DIVW-1:0] period_q, period_d;
    tick_mode_e      mode_q, mode_d;
    logic            armed_q, armed_d;
    logic            strobe_q, strobe_d;
    logic            wr_hit;

    // Indices >= NCH never match any channel, so such writes are dropped.
    assign wr_hit = cfg_we && (cfg_ch == CHW'(gi));

    always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      mode_d   = mode_q;
      armed_d  = armed_q;
      strobe_d = 1'b0;
      if (!ch_en[gi]) begin
        cnt_d   = '0;
        armed_d = 1'b1;
      end else if (wr_hit) begin
        // A write restarts the channel even on its terminal ms_tick.
        period_d = cfg_period;
        mode_d   = cfg_oneshot ? MODE_ONESHOT : MODE_PERIODIC;
        cnt_d    = '0;
        armed_d  = 1'b1;
      end else if (armed_q && (period_q != '0) && ms_tick) begin
        if (cnt_q == period_q - DIVW'(1)) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          if (mode_q == MODE_ONESHOT) begin
            armed_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIVW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= '0;
        period_q <= DIVW'(PERIOD_DEF);
        mode_q   <= MODE_PERIODIC;
        armed_q  <= 1'b1;
        strobe_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        period_q <= period_d;
        mode_q   <= mode_d;
        armed_q  <= armed_d;
        strobe_q <= strobe_d;
      end
    end

    assign strobe[gi] = strobe_q;
    assign busy[gi]   = ch_en[gi] && armed_q && (period_q != '0);

`ifdef MULTI_TICK_LED_EN
    logic led_q, led_d;

    // Toggle on the same edge that raises the strobe.
    always_comb begin
      led_d = led_q;
      if (!ch_en[gi]) begin
        led_d = 1'b0;
      end else if (strobe_d) begin
        led_d = ~led_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        led_q <= 1'b0;
      end else begin
        led_q <= led_d;
      end
    end

    assign led[gi] = led_q;
`endif
  end

endmodule
`default_nettype wire
